// File: rtl/escaner_teclado.sv
`default_nettype none
// ============================================================================
// Module   : escaner_teclado
// Purpose  : 4x4 matrix keypad scanner with debounce. Drives one active-low
//            column strobe at a time, samples the synchronized row lines once
//            per column dwell, and accepts a key only after REBOTE consecutive
//            matching samples of the same key (one sample per full scan).
//            A release is accepted the same way.
// Ports    : i_Clk        system clock (rising edge)
//            i_Rst_n      asynchronous active-low reset
//            i_Filas[3:0] row lines, active-low, asynchronous to i_Clk
//            o_Cols[3:0]  column strobes, active-low one-hot
//            o_Tecla[3:0] last accepted key code = fila*4 + columna
//            o_Valida     one-cycle pulse on each newly accepted press
//            o_Presionada high from press acceptance to release acceptance
// Revision : 1.0  initial release
// ============================================================================
module escaner_teclado #(
   parameter int DWELL  = 1000,
   parameter int REBOTE = 4
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic [3:0] i_Filas,
   output logic [3:0] o_Cols,
   output logic [3:0] o_Tecla,
   output logic       o_Valida,
   output logic       o_Presionada
);

   localparam int             CW           = $clog2(DWELL);
   localparam logic [CW-1:0]  C_DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0]  C_DWELL_ONE  = CW'(1);
   localparam logic [3:0]     C_REBOTE     = 4'(REBOTE);

   typedef enum logic [1:0] {
      ESCANEO  = 2'd0,
      CONFIRMA = 2'd1,
      SUELTA   = 2'd2
   } estado_t;

   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;      // filas_s: the only version of the rows used
   logic [CW-1:0] r_dwell;
   logic [1:0]    r_col;
   logic [1:0]    w_col_next;
   logic          w_sample;
   logic          w_cand_sample;
   logic          w_single;
   logic [1:0]    w_fila;
   estado_t       r_state;
   logic [1:0]    r_cand_fila;
   logic [1:0]    r_cand_col;
   logic [3:0]    r_match_cnt;
   logic [3:0]    r_rel_cnt;

   // ------------------------------------------------------------------------
   // Row synchronizer (rows idle high, so reset to all ones)
   // ------------------------------------------------------------------------
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_sync1 <= 4'hF;
         r_sync2 <= 4'hF;
      end else begin
         r_sync1 <= i_Filas;
         r_sync2 <= r_sync1;
      end
   end

   // ------------------------------------------------------------------------
   // Column scan: runs continuously regardless of the debounce state
   // ------------------------------------------------------------------------
   assign w_col_next = r_col + 2'd1;
   assign w_sample   = (r_dwell == C_DWELL_LAST);

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_dwell <= '0;
         r_col   <= 2'd0;
         o_Cols  <= 4'b1110;
      end else if (w_sample) begin
         r_dwell <= '0;
         r_col   <= w_col_next;
         // Strobe is decoded from the next index so it stays aligned with r_col
         case (w_col_next)
            2'd0:    o_Cols <= 4'b1110;
            2'd1:    o_Cols <= 4'b1101;
            2'd2:    o_Cols <= 4'b1011;
            default: o_Cols <= 4'b0111;
         endcase
      end else begin
         r_dwell <= r_dwell + C_DWELL_ONE;
      end
   end

   // ------------------------------------------------------------------------
   // Row decode: exactly one low row is a key; none or several is no key
   // ------------------------------------------------------------------------
   always_comb begin
      w_single = 1'b0;
      w_fila   = 2'd0;
      case (r_sync2)
         4'b1110: begin w_single = 1'b1; w_fila = 2'd0; end
         4'b1101: begin w_single = 1'b1; w_fila = 2'd1; end
         4'b1011: begin w_single = 1'b1; w_fila = 2'd2; end
         4'b0111: begin w_single = 1'b1; w_fila = 2'd3; end
         default: begin w_single = 1'b0; w_fila = 2'd0; end
      endcase
   end

   // Once a candidate exists, only its own column's sample matters
   assign w_cand_sample = w_sample && (r_col == r_cand_col);

   // ------------------------------------------------------------------------
   // Debounce state machine with registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_state      <= ESCANEO;
         r_cand_fila  <= 2'd0;
         r_cand_col   <= 2'd0;
         r_match_cnt  <= 4'd0;
         r_rel_cnt    <= 4'd0;
         o_Tecla      <= 4'd0;
         o_Valida     <= 1'b0;
         o_Presionada <= 1'b0;
      end else begin
         o_Valida <= 1'b0;
         case (r_state)
            ESCANEO: begin
               if (w_sample && w_single) begin
                  r_cand_fila <= w_fila;
                  r_cand_col  <= r_col;
                  r_match_cnt <= 4'd1;
                  r_state     <= CONFIRMA;
               end
            end
            CONFIRMA: begin
               if (w_cand_sample) begin
                  if (w_single && (w_fila == r_cand_fila)) begin
                     if ((r_match_cnt + 4'd1) >= C_REBOTE) begin
                        r_match_cnt  <= C_REBOTE;
                        r_rel_cnt    <= 4'd0;
                        o_Tecla      <= {r_cand_fila, r_cand_col};
                        o_Valida     <= 1'b1;
                        o_Presionada <= 1'b1;
                        r_state      <= SUELTA;
                     end else begin
                        r_match_cnt <= r_match_cnt + 4'd1;
                     end
                  end else begin
                     r_match_cnt <= 4'd0;
                     r_state     <= ESCANEO;
                  end
               end
            end
            SUELTA: begin
               // Only the held key's own row bit decides release; other
               // keys pressed meanwhile are ignored entirely.
               if (w_cand_sample) begin
                  if (r_sync2[r_cand_fila]) begin
                     if ((r_rel_cnt + 4'd1) >= C_REBOTE) begin
                        r_rel_cnt    <= 4'd0;
                        r_match_cnt  <= 4'd0;
                        o_Presionada <= 1'b0;
                        r_state      <= ESCANEO;
                     end else begin
                        r_rel_cnt <= r_rel_cnt + 4'd1;
                     end
                  end else begin
                     r_rel_cnt <= 4'd0;
                  end
               end
            end
            default: r_state <= ESCANEO;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_escaner_teclado.sv
`default_nettype none
// ============================================================================
// Module   : tb_escaner_teclado
// Purpose  : Self-checking bench for escaner_teclado (DWELL=4, REBOTE=3).
//            A keypad model turns a set of pressed keys into row levels for
//            the strobed column; a behavioural model derives the expected
//            outputs from edge counts and the input history.
// Revision : 1.0  initial release
// ============================================================================
module tb_escaner_teclado;

   localparam int D = 4;
   localparam int R = 3;

   logic       clk;
   logic       rst_n;
   logic [3:0] filas;
   logic [3:0] cols;
   logic [3:0] tecla;
   logic       valida;
   logic       presionada;

   int errors = 0;
   int checks = 0;
   int n_pulse = 0;

   logic [15:0] pressed;
   bit          noise;

   escaner_teclado #(.DWELL(D), .REBOTE(R)) dut (
      .i_Clk        (clk),
      .i_Rst_n      (rst_n),
      .i_Filas      (filas),
      .o_Cols       (cols),
      .o_Tecla      (tecla),
      .o_Valida     (valida),
      .o_Presionada (presionada)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Behavioural model: k = edges since reset release
   // ------------------------------------------------------------------------
   int         k;
   logic [3:0] hist[$];
   int         mode;          // 0 idle, 1 confirming, 2 held
   int         m_fila, m_col, m_cnt, m_rel;
   logic [3:0] e_cols, e_tecla;
   bit         e_val, e_pres;

   task automatic model_reset();
      k = 0; hist.delete(); mode = 0;
      m_fila = 0; m_col = 0; m_cnt = 0; m_rel = 0;
      e_cols = 4'b1110; e_tecla = 4'd0; e_val = 1'b0; e_pres = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] fin);
      logic [3:0] fs;
      int zeros, fila, col;
      // row value seen by the design is the input captured two edges ago
      fs = (hist.size() >= 2) ? hist[hist.size()-2] : 4'hF;
      hist.push_back(fin);
      if (hist.size() > 4) void'(hist.pop_front());
      k++;
      e_val = 1'b0;
      if (k % D == 0) begin
         col = ((k - 1) / D) % 4;
         zeros = 0; fila = 0;
         for (int r = 0; r < 4; r++) if (!fs[r]) begin zeros++; fila = r; end
         if (mode == 0) begin
            if (zeros == 1) begin
               m_fila = fila; m_col = col; m_cnt = 1; mode = 1;
            end
         end else if (mode == 1) begin
            if (col == m_col) begin
               if (zeros == 1 && fila == m_fila) begin
                  m_cnt++;
                  if (m_cnt >= R) begin
                     e_tecla = 4'(m_fila * 4 + m_col);
                     e_val = 1'b1; e_pres = 1'b1; mode = 2; m_rel = 0;
                  end
               end else begin
                  m_cnt = 0; mode = 0;
               end
            end
         end else begin
            if (col == m_col) begin
               if (fs[m_fila]) begin
                  m_rel++;
                  if (m_rel >= R) begin e_pres = 1'b0; mode = 0; m_cnt = 0; end
               end else begin
                  m_rel = 0;
               end
            end
         end
      end
      e_cols = ~(4'b0001 << ((k / D) % 4));
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Cycle-by-cycle compare against the model
   // ------------------------------------------------------------------------
   always @(posedge clk) begin : compare
      logic [3:0] fin;
      fin = filas;
      #1;
      if (!rst_n) model_reset();
      else        model_step(fin);
      chk("cols",       cols,                 e_cols);
      chk("tecla",      tecla,                e_tecla);
      chk("valida",     {3'b000, valida},     {3'b000, e_val});
      chk("presionada", {3'b000, presionada}, {3'b000, e_pres});
      if (valida) n_pulse++;
   end

   // ------------------------------------------------------------------------
   // Keypad: rows of pressed keys in the strobed column pull low
   // ------------------------------------------------------------------------
   task automatic drive();
      logic [3:0] v;
      v = 4'hF;
      for (int c = 0; c < 4; c++)
         if (!cols[c])
            for (int r = 0; r < 4; r++)
               if (pressed[r*4+c]) v[r] = 1'b0;
      if (noise && $urandom_range(0, 15) == 0) v = 4'($urandom);
      filas = v;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         drive();
      end
   endtask

   task automatic wait_col_start(input logic [3:0] target);
      int guard;
      guard = 0;
      while (cols == target && guard < 64) begin tick(1); guard++; end
      while (cols != target && guard < 64) begin tick(1); guard++; end
      checks++;
      if (guard >= 64) begin
         errors++;
         $display("FAIL wait_col: got %h expected %h (timeout)", cols, target);
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_cols"},  cols,                 4'b1110);
      chk({tag, "_tecla"}, tecla,                4'd0);
      chk({tag, "_val"},   {3'b000, valida},     4'd0);
      chk({tag, "_pres"},  {3'b000, presionada}, 4'd0);
   endtask

   initial begin : stim
      logic [3:0] seq [4];
      int base, guard, sel;
      seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
      rst_n = 1'b0; filas = 4'hF; pressed = '0; noise = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      rst_n = 1'b1;

      // Idle scan: strobe steps every D cycles, no pulses
      for (int s = 0; s < 4; s++) begin
         tick(D);
         chk("scan_seq", cols, seq[s]);
      end
      chk("idle_pulses", 4'(n_pulse), 4'd0);

      // Key 9 (fila 2, columna 1) held, then released
      pressed[9] = 1'b1;
      tick(16 * 4);
      chk("k9_pulses", 4'(n_pulse), 4'd1);
      chk("k9_tecla", tecla, 4'd9);
      chk("k9_pres", {3'b000, presionada}, 4'd1);
      pressed = '0;
      tick(16 * 4);
      chk("k9_release", {3'b000, presionada}, 4'd0);
      chk("k9_pulses2", 4'(n_pulse), 4'd1);

      // Bounce: fila 0 low during a single column-2 sample only
      wait_col_start(4'b1011);
      pressed[2] = 1'b1;
      drive();
      tick(3);
      pressed = '0;
      tick(64);
      chk("bounce_pulses", 4'(n_pulse), 4'd1);
      chk("bounce_tecla", tecla, 4'd9);

      // Rows 0 and 3 together on column 0: ambiguous, never accepted
      pressed[0] = 1'b1; pressed[12] = 1'b1;
      tick(5 * 16);
      chk("multi_pulses", 4'(n_pulse), 4'd1);
      pressed = '0;
      tick(32);

      // Key 6: reset after the second match, then a full new sequence
      base = n_pulse;
      pressed[6] = 1'b1;
      guard = 0;
      while (!(mode == 1 && m_cnt == 2) && guard < 200) begin tick(1); guard++; end
      checks++;
      if (guard >= 200) begin
         errors++;
         $display("FAIL k6_second_match: got timeout expected match count 2");
      end
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_rst");
      tick(2);
      rst_n = 1'b1;
      tick(32);
      chk("k6_no_early", 4'(n_pulse - base), 4'd0);
      tick(32);
      chk("k6_pulse", 4'(n_pulse - base), 4'd1);
      chk("k6_tecla", tecla, 4'd6);
      pressed = '0;
      tick(64);

      // Key 15 held long, key 4 pressed meanwhile, then key 4 alone
      base = n_pulse;
      pressed[15] = 1'b1;
      tick(160);
      pressed[4] = 1'b1;
      tick(160);
      chk("k15_pulses", 4'(n_pulse - base), 4'd1);
      chk("k15_tecla", tecla, 4'd15);
      chk("k15_pres", {3'b000, presionada}, 4'd1);
      pressed = '0;
      tick(80);
      chk("k15_release", {3'b000, presionada}, 4'd0);
      pressed[4] = 1'b1;
      tick(80);
      chk("k4_pulses", 4'(n_pulse - base), 4'd2);
      chk("k4_tecla", tecla, 4'd4);
      pressed = '0;
      tick(64);

      // Randomized presses, releases, glitches and occasional resets
      noise = 1'b1;
      for (int it = 0; it < 40; it++) begin
         pressed = '0;
         sel = $urandom_range(0, 9);
         if (sel < 8) pressed[$urandom_range(0, 15)] = 1'b1;
         if (sel >= 6 && sel < 8) pressed[$urandom_range(0, 15)] = 1'b1;
         tick($urandom_range(1, 200));
         pressed = '0;
         tick($urandom_range(1, 120));
         if ($urandom_range(0, 15) == 0) begin
            #3 rst_n = 1'b0;
            tick(1);
            rst_n = 1'b1;
         end
      end
      noise = 1'b0;
      tick(8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/escaner_teclado.md
ESCANER_TECLADO -- requirements
Module: escaner_teclado

Interface
REQ-001 SHALL have parameter DWELL, default 1000, clock cycles each column strobe is held active (legal range 4..65535).
REQ-002 SHALL have parameter REBOTE, default 4, consecutive matching scan samples required to accept a press or a release (legal range 2..15).
REQ-003 i_Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 i_Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_Filas  input  4  keypad row lines, active-low (external pull-ups), asynchronous to i_Clk.
REQ-006 o_Cols  output  4  column strobes, active-low one-hot: column 0..3 = 1110, 1101, 1011, 0111.
REQ-007 o_Tecla  output  4  code of the last accepted key = fila*4 + columna.
REQ-008 o_Valida  output  1  one-cycle pulse when a new key press is accepted.
REQ-009 o_Presionada  output  1  level, high from acceptance of a press until acceptance of its release.

Function
REQ-010 i_Filas SHALL pass through a 2-flop synchronizer before any use; the synchronized value is called filas_s.
REQ-011 Dwell counter SHALL count 0..DWELL-1 and wrap; on wrap the 2-bit column index SHALL advance 0->1->2->3->0; o_Cols SHALL be a registered decode of the column index.
REQ-012 Sample point: the cycle in which the dwell counter equals DWELL-1; filas_s is evaluated only at sample points, against the column currently strobed.
REQ-013 filas_s is "single" when exactly one bit is 0; fila index = position of that bit; zero or multiple low bits SHALL be treated as no key.
REQ-014 States: ESCANEO, CONFIRMA, SUELTA; reset state ESCANEO.
REQ-015 ESCANEO: at any sample point with single filas_s, capture candidate = {fila, columna}, set match count to 1, go CONFIRMA; otherwise remain.
REQ-016 CONFIRMA: only sample points of the candidate column are evaluated (one per full scan, 4*DWELL cycles apart); samples of other columns SHALL be ignored.
REQ-017 CONFIRMA, candidate-column sample, single with same fila: increment count; when count reaches REBOTE, load o_Tecla with candidate, pulse o_Valida, set o_Presionada, go SUELTA.
REQ-018 CONFIRMA, candidate-column sample, any other value: clear count, go ESCANEO, no output change.
REQ-019 o_Valida SHALL be high exactly one cycle, the cycle after the accepting sample point; o_Tecla and o_Presionada update in that same cycle.
REQ-020 SUELTA: at candidate-column samples, candidate fila bit high increments release count, low clears it; when release count reaches REBOTE, clear o_Presionada and go ESCANEO.
REQ-021 While in SUELTA no further o_Valida SHALL occur, regardless of other keys pressed; o_Tecla SHALL hold its value until the next accepted press.
REQ-022 Column scanning SHALL continue uninterrupted in every state.
REQ-023 Match and release counters SHALL saturate logic-wise at REBOTE (no wrap).

Reset
REQ-024 i_Rst_n low SHALL immediately force: o_Cols=1110, column index 0, dwell counter 0, state ESCANEO, both counts 0, synchronizer flops 1111, o_Tecla=0, o_Valida=0, o_Presionada=0.
REQ-025 Reset asserted mid-CONFIRMA or mid-SUELTA SHALL discard the candidate; after release a press needs a full REBOTE match sequence again.
REQ-026 First column advance after reset release SHALL occur DWELL cycles after the first active edge.

Verification (DWELL=4, REBOTE=3)
REQ-027 Reset with i_Filas=1111 -> all outputs at reset values; after release o_Cols cycles 1110,1101,1011,0111,1110 every 4 cycles, o_Valida never high.
REQ-028 Key fila 2/columna 1 held (i_Filas=1011 while o_Cols=1101) -> single o_Valida pulse after third column-1 sample, o_Tecla=9, o_Presionada=1; after release, o_Presionada=0 after 3 further column-1 samples.
REQ-029 Bounce: fila 0 low during one column-2 sample only -> no o_Valida, o_Tecla unchanged, state returns to ESCANEO.
REQ-030 Rows 0 and 3 low together on column 0 for 5 scans -> no o_Valida.
REQ-031 Reset pulse after second matching sample of key 6 -> outputs cleared asynchronously; continued hold yields o_Valida only after 3 new matches post-reset.
REQ-032 Key 15 held 10 scans, key 4 pressed meanwhile -> exactly one pulse (o_Tecla=15); release both, press key 4 -> second pulse with o_Tecla=4.
